axi_dma_nd_midend: RTL and testbench

AXI_DMA_ND_MIDEND -- requirements
Module: axi_dma_nd_midend

---
 rtl/axi_dma_nd_pkg.sv | 26 ++
 rtl/axi_dma_nd_counter.sv | 60 ++++++
 rtl/axi_dma_nd_midend.sv | 174 +++++++++++++++++
 tb/tb_axi_dma_nd_midend.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_nd_pkg.sv
// Shared types for the N-D DMA midend: job/burst bundles and the controller state encoding.
// Structs use the widest supported widths; the top narrows them to its parameters.
package axi_dma_nd_pkg;

  localparam int unsigned AddrMax = 64;
  localparam int unsigned LenMax  = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EMIT      = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [AddrMax-1:0] src_base;
    logic [AddrMax-1:0] dst_base;
    logic [LenMax-1:0]  num_bytes;
  } job_t;

  typedef struct packed {
    logic [AddrMax-1:0] src;
    logic [AddrMax-1:0] dst;
    logic [LenMax-1:0]  num_bytes;
  } burst_t;

endpackage

// File: rtl/axi_dma_nd_counter.sv
// One dimension of the N-D walk: repetition index, level base addresses and carry to the next level.
// The level base is the job base plus the contributions of this and all outer dimensions.
module axi_dma_nd_counter #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned RepWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [RepWidth-1:0]  reps_i,
  input  logic [AddrWidth-1:0] src_base_i,
  input  logic [AddrWidth-1:0] dst_base_i,
  input  logic [AddrWidth-1:0] src_stride_i,
  input  logic [AddrWidth-1:0] dst_stride_i,
  input  logic                 step_i,
  input  logic [AddrWidth-1:0] parent_src_i,
  input  logic [AddrWidth-1:0] parent_dst_i,
  output logic                 at_max_o,
  output logic                 carry_o,
  output logic [AddrWidth-1:0] next_src_o,
  output logic [AddrWidth-1:0] next_dst_o
);

  logic [RepWidth-1:0]  idx_q;
  logic [RepWidth-1:0]  reps_q;
  logic [AddrWidth-1:0] src_stride_q;
  logic [AddrWidth-1:0] dst_stride_q;
  logic [AddrWidth-1:0] src_q;
  logic [AddrWidth-1:0] dst_q;

  assign at_max_o = (idx_q == (reps_q - RepWidth'(1)));
  assign carry_o  = step_i & at_max_o;

  // On wrap this level restarts from the outer level's freshly advanced base.
  assign next_src_o = at_max_o ? parent_src_i : (src_q + src_stride_q);
  assign next_dst_o = at_max_o ? parent_dst_i : (dst_q + dst_stride_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q        <= '0;
      reps_q       <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      src_q        <= '0;
      dst_q        <= '0;
    end else if (load_i) begin
      idx_q        <= '0;
      reps_q       <= reps_i;
      src_stride_q <= src_stride_i;
      dst_stride_q <= dst_stride_i;
      src_q        <= src_base_i;
      dst_q        <= dst_base_i;
    end else if (step_i) begin
      idx_q <= at_max_o ? '0 : (idx_q + RepWidth'(1));
      src_q <= next_src_o;
      dst_q <= next_dst_o;
    end
  end

endmodule

// File: rtl/axi_dma_nd_midend.sv
// N-D DMA midend: splits an N-D job into 1D bursts, innermost dimension first.
// Completion tracking (nd_done_o, WAIT_DONE) is built only with AXI_DMA_ND_DONE_TRACK_EN defined.
//
//   state     | meaning
//   IDLE      | ready for a new job (nd_ready_o high)
//   EMIT      | presenting bursts to the backend, one per handshake
//   WAIT_DONE | all bursts issued, waiting for backend completions
module axi_dma_nd_midend
  import axi_dma_nd_pkg::*;
#(
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned LenWidth   = 32,
  parameter int unsigned RepWidth   = 32,
  parameter int unsigned NumDim     = 2,
  parameter int unsigned OutstWidth = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               nd_valid_i,
  output logic                               nd_ready_o,
  input  logic [AddrWidth-1:0]               src_addr_i,
  input  logic [AddrWidth-1:0]               dst_addr_i,
  input  logic [LenWidth-1:0]                num_bytes_i,
  input  logic [NumDim-2:0][RepWidth-1:0]    reps_i,
  input  logic [NumDim-2:0][AddrWidth-1:0]   src_strides_i,
  input  logic [NumDim-2:0][AddrWidth-1:0]   dst_strides_i,
  output logic                               burst_valid_o,
  input  logic                               burst_ready_i,
  output logic [AddrWidth-1:0]               burst_src_o,
  output logic [AddrWidth-1:0]               burst_dst_o,
  output logic [LenWidth-1:0]                burst_num_bytes_o,
  output logic                               burst_last_o,
  input  logic                               be_done_i,
  output logic                               nd_done_o
);

  localparam int unsigned NumLvl = NumDim - 1;

`ifdef AXI_DMA_ND_DONE_TRACK_EN
  localparam state_e EndState = WAIT_DONE;
`else
  localparam state_e EndState = IDLE;
`endif

  state_e                       state_q;
  burst_t                       burst_q;
  job_t                         job_in;
  logic                         valid_q;
  logic                         start;
  logic                         zero_len;
  logic                         hs;
  logic                         last;
  logic [NumLvl-1:0]            at_max;
  logic [NumLvl:0]              step;
  logic [NumLvl:0][AddrWidth-1:0] nxt_src;
  logic [NumLvl:0][AddrWidth-1:0] nxt_dst;
  logic                         unused_top_carry;

  assign job_in = '{src_base:  AddrMax'(src_addr_i),
                    dst_base:  AddrMax'(dst_addr_i),
                    num_bytes: LenMax'(num_bytes_i)};

  always_comb begin
    zero_len = (num_bytes_i == '0);
    for (int i = 0; i < int'(NumLvl); i++) begin
      if (reps_i[i] == '0) zero_len = 1'b1;
    end
  end

  assign start = (state_q == IDLE) && nd_valid_i;
  assign last  = valid_q && (&at_max);
  assign hs    = burst_valid_o && burst_ready_i;

  // The outermost level never wraps while a job is running, so its parent base is unused.
  assign step[0]          = hs && !last;
  assign nxt_src[NumLvl]  = '0;
  assign nxt_dst[NumLvl]  = '0;
  assign unused_top_carry = step[NumLvl];

  for (genvar i = 0; i < NumLvl; i++) begin : g_dim
    axi_dma_nd_counter #(
      .AddrWidth (AddrWidth),
      .RepWidth  (RepWidth)
    ) u_cnt (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_i       (start),
      .reps_i       (reps_i[i]),
      .src_base_i   (src_addr_i),
      .dst_base_i   (dst_addr_i),
      .src_stride_i (src_strides_i[i]),
      .dst_stride_i (dst_strides_i[i]),
      .step_i       (step[i]),
      .parent_src_i (nxt_src[i+1]),
      .parent_dst_i (nxt_dst[i+1]),
      .at_max_o     (at_max[i]),
      .carry_o      (step[i+1]),
      .next_src_o   (nxt_src[i]),
      .next_dst_o   (nxt_dst[i])
    );
  end

`ifdef AXI_DMA_ND_DONE_TRACK_EN
  logic [OutstWidth-1:0] outst_q;
  logic                  outst_full;

  assign outst_full = &outst_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_q <= '0;
    end else if (hs && !be_done_i) begin
      outst_q <= outst_q + OutstWidth'(1);
    end else if (!hs && be_done_i && (outst_q != '0)) begin
      outst_q <= outst_q - OutstWidth'(1);
    end
  end

  assign burst_valid_o = valid_q && !outst_full;
  assign nd_done_o     = (state_q == WAIT_DONE) && (outst_q == '0);
`else
  logic unused_be_done;

  assign unused_be_done = be_done_i;
  assign burst_valid_o  = valid_q;
  assign nd_done_o      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      burst_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (nd_valid_i) begin
            burst_q <= '{src: job_in.src_base, dst: job_in.dst_base, num_bytes: job_in.num_bytes};
            if (zero_len) begin
              state_q <= EndState;
            end else begin
              state_q <= EMIT;
              valid_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (hs) begin
            if (last) begin
              valid_q <= 1'b0;
              state_q <= EndState;
            end else begin
              burst_q.src <= AddrMax'(nxt_src[0]);
              burst_q.dst <= AddrMax'(nxt_dst[0]);
            end
          end
        end
`ifdef AXI_DMA_ND_DONE_TRACK_EN
        WAIT_DONE: begin
          if (outst_q == '0) state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign nd_ready_o        = (state_q == IDLE);
  assign burst_src_o       = burst_q.src[AddrWidth-1:0];
  assign burst_dst_o       = burst_q.dst[AddrWidth-1:0];
  assign burst_num_bytes_o = burst_q.num_bytes[LenWidth-1:0];
  assign burst_last_o      = last;

endmodule

// File: tb/tb_axi_dma_nd_midend.sv
// Randomized bench for axi_dma_nd_midend against a nested-loop burst model, plus directed jobs.
// Completion checks follow AXI_DMA_ND_DONE_TRACK_EN when the design is built with it.
module tb_axi_dma_nd_midend;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              nd_valid = 1'b0;
  logic              nd_ready;
  logic [63:0]       src_addr = '0, dst_addr = '0;
  logic [31:0]       num_bytes = '0;
  logic [1:0][31:0]  reps = '0;
  logic [1:0][63:0]  src_strides = '0, dst_strides = '0;
  logic              burst_valid;
  logic              burst_ready = 1'b0;
  logic [63:0]       burst_src, burst_dst;
  logic [31:0]       burst_nb;
  logic              burst_last;
  logic              be_done = 1'b0;
  logic              nd_done;

  axi_dma_nd_midend #(
    .AddrWidth(64), .LenWidth(32), .RepWidth(32), .NumDim(ND), .OutstWidth(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .nd_valid_i(nd_valid), .nd_ready_o(nd_ready),
    .src_addr_i(src_addr), .dst_addr_i(dst_addr), .num_bytes_i(num_bytes),
    .reps_i(reps), .src_strides_i(src_strides), .dst_strides_i(dst_strides),
    .burst_valid_o(burst_valid), .burst_ready_i(burst_ready),
    .burst_src_o(burst_src), .burst_dst_o(burst_dst),
    .burst_num_bytes_o(burst_nb), .burst_last_o(burst_last),
    .be_done_i(be_done), .nd_done_o(nd_done)
  );

  typedef struct {
    logic [63:0] src, dst;
    logic [31:0] nb;
    int unsigned r1, r2;
    logic [63:0] ss1, ss2, ds1, ds2;
  } job_s;

  typedef struct {
    logic [63:0] src, dst;
    logic        last;
  } exp_s;

  typedef enum {M_IDLE, M_EMIT, M_WAITD} mmode_e;

  int          n_tests = 0;
  int          n_fail = 0;
  mmode_e      m_mode = M_IDLE;
  exp_s        m_q[$];
  exp_s        gen_q[$];
  logic [31:0] m_nb = '0;
  int          m_outst = 0;
  int unsigned due_q[$];
  int unsigned now = 0;
  job_s        cur_job;
  bit          start_req = 0;
  bit          rst_req = 0;
  bit          chk_zero = 1;
  int          ready_mode = 0;
  int          hs_in_job = 0;
  int          stall_cnt = 0;
  int          cpl_fixed = 0;

  function automatic void chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Expected burst list: address = base + i1*stride1 + i2*stride2, dimension 1 fastest.
  function automatic void gen(input job_s j);
    exp_s e;
    gen_q.delete();
    if (j.nb == 0 || j.r1 == 0 || j.r2 == 0) return;
    for (int unsigned i2 = 0; i2 < j.r2; i2++) begin
      for (int unsigned i1 = 0; i1 < j.r1; i1++) begin
        e.src  = j.src + 64'(i1) * j.ss1 + 64'(i2) * j.ss2;
        e.dst  = j.dst + 64'(i1) * j.ds1 + 64'(i2) * j.ds2;
        e.last = (i1 == j.r1 - 1) && (i2 == j.r2 - 1);
        gen_q.push_back(e);
      end
    end
  endfunction

  task automatic check();
    chk1("nd_ready", nd_ready, m_mode == M_IDLE);
    chk1("burst_valid", burst_valid, m_mode == M_EMIT);
    if (m_mode == M_EMIT) begin
      chk64("burst_src", burst_src, m_q[0].src);
      chk64("burst_dst", burst_dst, m_q[0].dst);
      chk64("burst_num_bytes", 64'(burst_nb), 64'(m_nb));
      chk1("burst_last", burst_last, m_q[0].last);
    end
`ifdef AXI_DMA_ND_DONE_TRACK_EN
    chk1("nd_done", nd_done, (m_mode == M_WAITD) && (m_outst == 0));
`else
    chk1("nd_done", nd_done, 1'b0);
`endif
    if (chk_zero) begin
      chk64("rst_burst_src", burst_src, 64'h0);
      chk64("rst_burst_dst", burst_dst, 64'h0);
      chk64("rst_burst_nb", 64'(burst_nb), 64'h0);
      chk1("rst_burst_last", burst_last, 1'b0);
      chk_zero = 0;
    end
  endtask

  task automatic step();
    bit acc, hs, bd, wexit;
    @(negedge clk);
    now++;
    check();
    if (rst_req) begin
      rst = 1'b1; rst_req = 0; start_req = 0;
      nd_valid = 1'b0; burst_ready = 1'b0; be_done = 1'b0;
      m_mode = M_IDLE; m_q.delete(); m_outst = 0; due_q.delete(); chk_zero = 1;
      return;
    end
    rst = 1'b0;
    acc = start_req && (m_mode == M_IDLE);
    if (acc) begin
      nd_valid = 1'b1;
      src_addr = cur_job.src; dst_addr = cur_job.dst; num_bytes = cur_job.nb;
      reps[0] = cur_job.r1; reps[1] = cur_job.r2;
      src_strides[0] = cur_job.ss1; src_strides[1] = cur_job.ss2;
      dst_strides[0] = cur_job.ds1; dst_strides[1] = cur_job.ds2;
    end else begin
      nd_valid = (m_mode != M_IDLE) ? 1'($urandom_range(0, 1)) : 1'b0;
      src_addr = {$urandom, $urandom}; dst_addr = {$urandom, $urandom};
      num_bytes = $urandom; reps[0] = $urandom; reps[1] = $urandom;
      src_strides[0] = {$urandom, $urandom}; src_strides[1] = {$urandom, $urandom};
      dst_strides[0] = {$urandom, $urandom}; dst_strides[1] = {$urandom, $urandom};
    end
    case (ready_mode)
      0: burst_ready = 1'b1;
      1: burst_ready = 1'($urandom_range(0, 1));
      default: begin
        if (m_mode == M_EMIT && hs_in_job == 1 && stall_cnt < 5) begin
          burst_ready = 1'b0;
          stall_cnt++;
        end else begin
          burst_ready = 1'b1;
        end
      end
    endcase
    hs = (m_mode == M_EMIT) && burst_ready;
`ifdef AXI_DMA_ND_DONE_TRACK_EN
    bd = (due_q.size() > 0) && (due_q[0] <= now);
    if (bd) void'(due_q.pop_front());
`else
    bd = 1'($urandom_range(0, 1));
`endif
    be_done = bd;
    wexit = (m_mode == M_WAITD) && (m_outst == 0);
`ifdef AXI_DMA_ND_DONE_TRACK_EN
    m_outst += int'(hs) - int'(bd);
`endif
    if (acc) begin
      start_req = 0; hs_in_job = 0; stall_cnt = 0;
      m_nb = cur_job.nb;
      gen(cur_job);
      m_q = gen_q;
`ifdef AXI_DMA_ND_DONE_TRACK_EN
      m_mode = (m_q.size() == 0) ? M_WAITD : M_EMIT;
`else
      m_mode = (m_q.size() == 0) ? M_IDLE : M_EMIT;
`endif
    end else if (hs) begin
      void'(m_q.pop_front());
      hs_in_job++;
`ifdef AXI_DMA_ND_DONE_TRACK_EN
      due_q.push_back(now + ((cpl_fixed > 0) ? cpl_fixed : $urandom_range(1, 12)));
      if (m_q.size() == 0) m_mode = M_WAITD;
`else
      if (m_q.size() == 0) m_mode = M_IDLE;
`endif
    end else if (wexit) begin
      m_mode = M_IDLE;
    end
  endtask

  task automatic run_job(input job_s j, input int rmode, input int cpl);
    cur_job = j; ready_mode = rmode; cpl_fixed = cpl; start_req = 1;
    for (int c = 0; c < 2000; c++) begin
      step();
      if (!start_req && m_mode == M_IDLE && due_q.size() == 0) return;
    end
    n_tests++; n_fail++;
    $display("FAIL job_timeout: job still active after 2000 cycles, required idle");
  endtask

  function automatic job_s mk(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] nb,
                              input int unsigned r1, input int unsigned r2,
                              input logic [63:0] ss1, input logic [63:0] ss2,
                              input logic [63:0] ds1, input logic [63:0] ds2);
    job_s j;
    j.src = src; j.dst = dst; j.nb = nb; j.r1 = r1; j.r2 = r2;
    j.ss1 = ss1; j.ss2 = ss2; j.ds1 = ds1; j.ds2 = ds2;
    return j;
  endfunction

  initial begin
    job_s j37, j39, j41, jz, jr;
    step();

    // 2D job on the 3D instance: outer repetition of 1
    j37 = mk(64'h1000, 64'h8000, 32'd16, 3, 1, 64'h100, 64'h5555, 64'h40, 64'h7777);
    gen(j37);
    chk64("pin37_count", 64'(gen_q.size()), 64'd3);
    chk64("pin37_src1", gen_q[1].src, 64'h1100);
    chk64("pin37_src2", gen_q[2].src, 64'h1200);
    chk64("pin37_dst2", gen_q[2].dst, 64'h8080);
    chk1("pin37_last2", gen_q[2].last, 1'b1);
    run_job(j37, 0, 0);
    run_job(j37, 2, 0);

    j39 = mk(64'h0, 64'h2000, 32'd8, 2, 2, 64'h10, 64'h1000, 64'h4, 64'h400);
    gen(j39);
    chk64("pin39_src1", gen_q[1].src, 64'h10);
    chk64("pin39_src2", gen_q[2].src, 64'h1000);
    chk64("pin39_src3", gen_q[3].src, 64'h1010);
    run_job(j39, 1, 0);

    j41 = mk(64'hFFFF_FFFF_FFFF_FF00, 64'h0, 32'd4, 2, 1, 64'h100, 64'h0, 64'h8, 64'h0);
    gen(j41);
    chk64("pin41_src1", gen_q[1].src, 64'h0);
    run_job(j41, 0, 0);

    jz = mk(64'h1000, 64'h8000, 32'd16, 0, 1, 64'h100, 64'h0, 64'h40, 64'h0);
    gen(jz);
    chk64("pin40_count", 64'(gen_q.size()), 64'd0);
    run_job(jz, 0, 0);
    jz.r1 = 3; jz.r2 = 0;
    run_job(jz, 1, 0);
    jz.r2 = 1; jz.nb = 0;
    run_job(jz, 0, 0);

    // reset in the middle of emission, then a clean job with slow completions
    cur_job = mk(64'h4000, 64'h9000, 32'd32, 4, 2, 64'h20, 64'h200, 64'h20, 64'h200);
    ready_mode = 0; cpl_fixed = 0; start_req = 1;
    step(); step(); step();
    rst_req = 1;
    step(); step();
    run_job(j37, 0, 10);

    for (int k = 0; k < 40; k++) begin
      jr = mk({$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom,
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3),
              {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom});
      run_job(jr, $urandom_range(0, 1), 0);
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
